ifetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the controller; produces the registered 32-bit ibus word the controller decodes.
- Holds the program counter and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and drives ibus through an IF/ID register that supports stall, redirect/flush and bubble insertion.

---
 rtl/ifetch_unit_if.sv | 26 ++
 rtl/ifetch_unit.sv | 144 ++++++++++++++
 tb/tb_ifetch_unit.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch-side bundle: instruction memory req/ack bus, downstream control and the IF/ID output.
// With IFETCH_PC_TRACE_EN defined the bundle also carries ibus_pc.
interface ifetch_unit_if;
    logic        ireq;
    logic [31:0] iaddr;
    logic        iack;
    logic [31:0] idata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ibus;
    logic        ibus_valid;
`ifdef IFETCH_PC_TRACE_EN
    logic [31:0] ibus_pc;

    modport master (output ireq, iaddr, ibus, ibus_valid, ibus_pc,
                    input  iack, idata, stall, redirect, redirect_pc);
    modport slave  (input  ireq, iaddr, ibus, ibus_valid, ibus_pc,
                    output iack, idata, stall, redirect, redirect_pc);
`else
    modport master (output ireq, iaddr, ibus, ibus_valid,
                    input  iack, idata, stall, redirect, redirect_pc);
    modport slave  (input  ireq, iaddr, ibus, ibus_valid,
                    output iack, idata, stall, redirect, redirect_pc);
`endif
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC, req/ack fetch FSM, prefetch FIFO and the IF/ID register driving ibus.
// Optional IFETCH_PC_TRACE_EN adds ibus_pc, the PC of the word currently held in ibus.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    ifetch_unit_if.master bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef IFETCH_PC_TRACE_EN
    localparam int FW = 64;
`else
    localparam int FW = 32;
`endif

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt, drop_addr, tgt_pc;
    logic [FW-1:0] fifo_mem [DEPTH];
    logic [FW-1:0] push_word_p0, head_p0;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, nxt_cnt;
    logic          push, pop, has_room;
    logic [31:0]   ibus_p1;
    logic          vld_p1;

    assign tgt_pc   = word_align(bus.redirect_pc);
    assign push     = (state == REQ) && bus.iack && !bus.redirect;
    assign pop      = !bus.redirect && !bus.stall && (count != '0);
    // A redirect empties the FIFO this edge, so the reservation check sees zero entries.
    assign nxt_cnt  = bus.redirect ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    assign has_room = nxt_cnt < (AW+1)'(DEPTH);

`ifdef IFETCH_PC_TRACE_EN
    assign push_word_p0 = {pc, bus.idata};
`else
    assign push_word_p0 = bus.idata;
`endif
    assign head_p0 = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            IDLE: begin
                if (bus.redirect) pc_nxt = tgt_pc;
                if (has_room)     state_nxt = REQ;
            end
            REQ: begin
                if (bus.redirect) begin
                    pc_nxt    = tgt_pc;
                    // An unacknowledged request cannot be withdrawn; its data must be swallowed.
                    state_nxt = bus.iack ? REQ : DROP;
                end else if (bus.iack) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = has_room ? REQ : IDLE;
                end
            end
            DROP: begin
                if (bus.redirect) pc_nxt = tgt_pc;
                if (bus.iack)     state_nxt = REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // The stale request keeps its address on the bus until memory accepts it.
    always_ff @(posedge clk) begin
        if (state == REQ && state_nxt == DROP) drop_addr <= pc;
    end

    assign bus.ireq  = (state != IDLE);
    assign bus.iaddr = (state == DROP) ? drop_addr : pc;

    // ---- stage 0: prefetch FIFO ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= nxt_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_word_p0;
    end

    // ---- stage 1: IF/ID register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ibus_p1 <= NOP_WORD;
            vld_p1  <= 1'b0;
        end else if (bus.redirect) begin
            ibus_p1 <= NOP_WORD;
            vld_p1  <= 1'b0;
        end else if (pop) begin
            ibus_p1 <= head_p0[31:0];
            vld_p1  <= 1'b1;
        end else if (!bus.stall) begin
            ibus_p1 <= NOP_WORD;
            vld_p1  <= 1'b0;
        end
    end

    assign bus.ibus       = ibus_p1;
    assign bus.ibus_valid = vld_p1;

`ifdef IFETCH_PC_TRACE_EN
    logic [31:0] ipc_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  ipc_p1 <= RESET_PC;
        else if (pop)  ipc_p1 <= head_p0[63:32];
    end

    assign bus.ibus_pc = ipc_p1;
`endif
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed latency/stall/redirect/reset scenarios plus a randomized
// run checked against an in-order instruction-stream model of the fetch unit.
module tb_ifetch_unit;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    int   ack_delay = 0;
    bit   rand_delay = 1'b0;
    int   wcnt = 0;
    bit   last_ireq = 1'b0;

    always #5 clk = ~clk;

    ifetch_unit_if bus();
    ifetch_unit_if wbus();

    ifetch_unit #(.RESET_PC(32'h0), .NOP_WORD(NOP), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    ifetch_unit #(.RESET_PC(WRAP_PC), .NOP_WORD(NOP), .DEPTH(2)) dut_w (
        .clk(clk), .reset_n(reset_n), .bus(wbus));

    // Memory returns the fetch address as the instruction word.
    assign bus.idata        = bus.iaddr;
    assign wbus.idata       = wbus.iaddr;
    assign wbus.iack        = 1'b1;
    assign wbus.stall       = 1'b0;
    assign wbus.redirect    = 1'b0;
    assign wbus.redirect_pc = 32'h0;

    // Memory responder: acknowledges each request ack_delay cycles after it is issued.
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt = 0;
            last_ireq = 1'b0;
            bus.iack = 1'b0;
        end else begin
            if (bus.ireq) begin
                if (!last_ireq || bus.iack) begin
                    wcnt = 0;
                    if (rand_delay) ack_delay = $urandom_range(0, 3);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            last_ireq = bus.ireq;
            bus.iack = (ack_delay == 0) ? 1'b1 : (bus.ireq && wcnt >= ack_delay);
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.ireq !== 1'b0 || bus.iaddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got ireq=%b iaddr=%h, want ireq=0 iaddr=00000000", bus.ireq, bus.iaddr);
        end
        checks++;
        if (bus.ibus !== NOP || bus.ibus_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ibus: got ibus=%h valid=%b, want ibus=%h valid=0", bus.ibus, bus.ibus_valid, NOP);
        end
        checks++;
        if (wbus.iaddr !== WRAP_PC || wbus.ireq !== 1'b0) begin
            errors++;
            $display("FAIL reset_wrap_pc: got iaddr=%h ireq=%b, want iaddr=%h ireq=0", wbus.iaddr, wbus.ireq, WRAP_PC);
        end
`ifdef IFETCH_PC_TRACE_EN
        checks++;
        if (bus.ibus_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_ibus_pc: got %h, want 00000000", bus.ibus_pc);
        end
`endif
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp;
        ack_delay = 0;
        rand_delay = 1'b0;
        do_reset();
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            checks++;
            if (e <= 2) begin
                if (bus.ibus_valid !== 1'b0 || bus.ibus !== NOP) begin
                    errors++;
                    $display("FAIL zero_wait_lead e=%0d: got valid=%b ibus=%h, want valid=0 ibus=%h",
                             e, bus.ibus_valid, bus.ibus, NOP);
                end
            end else begin
                exp = 32'((e - 3) * 4);
                if (bus.ibus_valid !== 1'b1 || bus.ibus !== exp) begin
                    errors++;
                    $display("FAIL zero_wait_word e=%0d: got valid=%b ibus=%h, want valid=1 ibus=%h",
                             e, bus.ibus_valid, bus.ibus, exp);
                end
            end
        end
    endtask

    // Continues straight from test_zero_wait with 0x8 in ibus.
    task automatic test_stall();
        logic [31:0] exp;
        @(negedge clk);
        bus.stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.ibus !== 32'h8 || bus.ibus_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold i=%0d: got ibus=%h valid=%b, want ibus=00000008 valid=1",
                         i, bus.ibus, bus.ibus_valid);
            end
            if (i >= 2) begin
                checks++;
                if (bus.ireq !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_full_ireq i=%0d: got ireq=%b, want 0", i, bus.ireq);
                end
            end
        end
        @(negedge clk);
        bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp = 32'hC + 32'(4 * i);
            checks++;
            if (bus.ibus !== exp || bus.ibus_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_release i=%0d: got ibus=%h valid=%b, want ibus=%h valid=1",
                         i, bus.ibus, bus.ibus_valid, exp);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] exp, pre_addr;
        logic        pre_req, pre_ack;
        int          nvalid, bubbles;
        ack_delay = 3;
        rand_delay = 1'b0;
        do_reset();
        exp = 32'h0;
        nvalid = 0;
        bubbles = 0;
        for (int c = 0; c < 40 && nvalid < 2; c++) begin
            @(negedge clk); #2;
            pre_req = bus.ireq; pre_ack = bus.iack; pre_addr = bus.iaddr;
            @(posedge clk); #1;
            if (pre_req && !pre_ack) begin
                checks++;
                if (bus.ireq !== 1'b1 || bus.iaddr !== pre_addr) begin
                    errors++;
                    $display("FAIL wait_addr_stable: got ireq=%b iaddr=%h, want ireq=1 iaddr=%h",
                             bus.ireq, bus.iaddr, pre_addr);
                end
            end
            checks++;
            if (bus.ibus_valid === 1'b1) begin
                if (bus.ibus !== exp) begin
                    errors++;
                    $display("FAIL wait_order: got ibus=%h, want %h", bus.ibus, exp);
                end
                exp += 32'd4;
                nvalid++;
            end else begin
                if (bus.ibus !== NOP) begin
                    errors++;
                    $display("FAIL wait_bubble: got ibus=%h, want %h", bus.ibus, NOP);
                end
                if (nvalid == 1) bubbles++;
            end
        end
        checks++;
        if (nvalid != 2 || bubbles == 0) begin
            errors++;
            $display("FAIL wait_progress: got words=%0d bubbles=%0d, want words=2 bubbles>0", nvalid, bubbles);
        end
    endtask

    task automatic test_redirect_drop();
        bit found;
        ack_delay = 2;
        rand_delay = 1'b0;
        do_reset();
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk); #2;
            if (bus.ireq === 1'b1 && bus.iaddr === 32'h8) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_setup: request to 00000008 never seen, want it within 40 cycles");
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        @(posedge clk); #1;
        checks++;
        if (bus.ireq !== 1'b1 || bus.iaddr !== 32'h8 || bus.ibus_valid !== 1'b0 || bus.ibus !== NOP) begin
            errors++;
            $display("FAIL redir_drop_edge: got ireq=%b iaddr=%h valid=%b ibus=%h, want ireq=1 iaddr=00000008 valid=0 ibus=%h",
                     bus.ireq, bus.iaddr, bus.ibus_valid, bus.ibus, NOP);
        end
        @(negedge clk);
        bus.redirect = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(posedge clk); #1;
            if (bus.ireq === 1'b1 && bus.iaddr === 32'h100) begin
                found = 1'b1;
            end else begin
                checks++;
                if (bus.iaddr !== 32'h8 || bus.ibus_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL redir_drop_wait: got iaddr=%h valid=%b, want iaddr=00000008 valid=0",
                             bus.iaddr, bus.ibus_valid);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL redir_new_addr: iaddr 00000100 not issued, last iaddr=%h", bus.iaddr);
        end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (bus.ibus_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || bus.ibus !== 32'h100) begin
            errors++;
            $display("FAIL redir_target: got valid=%b ibus=%h, want valid=1 ibus=00000100", bus.ibus_valid, bus.ibus);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        do_reset();
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if (e <= 2) begin
                if (wbus.ibus_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_lead e=%0d: got valid=%b, want 0", e, wbus.ibus_valid);
                end
            end else begin
                exp = WRAP_PC + 32'(4 * (e - 3));
                if (wbus.ibus_valid !== 1'b1 || wbus.ibus !== exp) begin
                    errors++;
                    $display("FAIL wrap_word e=%0d: got valid=%b ibus=%h, want valid=1 ibus=%h",
                             e, wbus.ibus_valid, wbus.ibus, exp);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, pre_addr, prev_ibus, rpc;
        logic        pre_req, pre_ack, prev_vld, s, r;
`ifdef IFETCH_PC_TRACE_EN
        logic [31:0] prev_pc;
`endif
        int          run;
        rand_delay = 1'b1;
        ack_delay = 1;
        do_reset();
        exp_pc = 32'h0;
        run = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 19) == 0);
            rpc = $urandom;
            bus.stall = s;
            bus.redirect = r;
            bus.redirect_pc = rpc;
            #2;
            pre_req = bus.ireq; pre_ack = bus.iack; pre_addr = bus.iaddr;
            prev_ibus = bus.ibus; prev_vld = bus.ibus_valid;
`ifdef IFETCH_PC_TRACE_EN
            prev_pc = bus.ibus_pc;
`endif
            @(posedge clk); #1;
            checks++;
            if (r) begin
                if (bus.ibus_valid !== 1'b0 || bus.ibus !== NOP) begin
                    errors++;
                    $display("FAIL rnd_redirect c=%0d: got valid=%b ibus=%h, want valid=0 ibus=%h",
                             c, bus.ibus_valid, bus.ibus, NOP);
                end
                exp_pc = {rpc[31:2], 2'b00};
            end else if (s) begin
                if (bus.ibus !== prev_ibus || bus.ibus_valid !== prev_vld) begin
                    errors++;
                    $display("FAIL rnd_stall c=%0d: got ibus=%h valid=%b, want ibus=%h valid=%b",
                             c, bus.ibus, bus.ibus_valid, prev_ibus, prev_vld);
                end
            end else if (bus.ibus_valid === 1'b1) begin
                if (bus.ibus !== exp_pc) begin
                    errors++;
                    $display("FAIL rnd_stream c=%0d: got ibus=%h, want %h", c, bus.ibus, exp_pc);
                end
                exp_pc += 32'd4;
            end else if (bus.ibus !== NOP) begin
                errors++;
                $display("FAIL rnd_bubble c=%0d: got ibus=%h, want %h", c, bus.ibus, NOP);
            end
            if (pre_req && !pre_ack) begin
                checks++;
                if (bus.ireq !== 1'b1 || bus.iaddr !== pre_addr) begin
                    errors++;
                    $display("FAIL rnd_addr_stable c=%0d: got ireq=%b iaddr=%h, want ireq=1 iaddr=%h",
                             c, bus.ireq, bus.iaddr, pre_addr);
                end
            end
            run = (!s && !r && bus.ibus_valid !== 1'b1) ? run + 1 : 0;
            checks++;
            if (run > 12) begin
                errors++;
                $display("FAIL rnd_progress c=%0d: got %0d free cycles without a word, want <=12", c, run);
                run = 0;
            end
`ifdef IFETCH_PC_TRACE_EN
            checks++;
            if (!r && !s && bus.ibus_valid === 1'b1) begin
                if (bus.ibus_pc !== bus.ibus) begin
                    errors++;
                    $display("FAIL rnd_ibus_pc c=%0d: got %h, want %h", c, bus.ibus_pc, bus.ibus);
                end
            end else if (bus.ibus_pc !== prev_pc) begin
                errors++;
                $display("FAIL rnd_ibus_pc_hold c=%0d: got %h, want %h", c, bus.ibus_pc, prev_pc);
            end
`endif
        end
        @(negedge clk);
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        rand_delay = 1'b0;
    endtask

    task automatic test_async_reset();
        ack_delay = 0;
        rand_delay = 1'b0;
        do_reset();
        repeat (6) @(posedge clk);
        #3;
        checks++;
        if (bus.ireq !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got ireq=%b, want 1", bus.ireq);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.ireq !== 1'b0 || bus.ibus !== NOP || bus.ibus_valid !== 1'b0 || bus.iaddr !== 32'h0) begin
            errors++;
            $display("FAIL areset_immediate: got ireq=%b ibus=%h valid=%b iaddr=%h, want ireq=0 ibus=%h valid=0 iaddr=00000000",
                     bus.ireq, bus.ibus, bus.ibus_valid, bus.iaddr, NOP);
        end
        @(negedge clk);
        #1 reset_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (e >= 3) begin
                checks++;
                if (bus.ibus_valid !== 1'b1 || bus.ibus !== 32'(4 * (e - 3))) begin
                    errors++;
                    $display("FAIL areset_restart e=%0d: got valid=%b ibus=%h, want valid=1 ibus=%h",
                             e, bus.ibus_valid, bus.ibus, 32'(4 * (e - 3)));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_zero_wait();
        test_stall();
        test_wait_states();
        test_redirect_drop();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
